// File: rtl/gps_scenario_sequencer.sv
// Steps gps_gen_core through a circular table of scenarios,
// holding each one for a programmable number of C/A epochs.
module gps_scenario_sequencer #(
  parameter int N_ENTRIES = 4,
  parameter int DWELL_W   = 8,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int DW = 37 + DWELL_W
) (
  input  logic          clk_in,
  input  logic          rst_in_n,
  input  logic          ena_in,
  input  logic          cfg_we_in,
  input  logic [AW-1:0] cfg_addr_in,
  input  logic [DW-1:0] cfg_data_in,
  input  logic          cfg_clr_in,
  input  logic          epoch_in,
  output logic          core_ena_out,
  output logic [4:0]    n_sat_out,
  output logic [7:0]    doppler_out,
  output logic [7:0]    snr_out,
  output logic [15:0]   ca_phase_out,
  output logic          ca_phase_start_out,
  output logic [AW-1:0] entry_idx_out,
  output logic          busy_out,
  output logic          wrap_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DWELL, S_NEXT
  } state_t;

  state_t               state;
  logic [DW-1:0]        tbl [N_ENTRIES];
  logic [N_ENTRIES-1:0] valid;
  logic [AW-1:0]        idx;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   cnt;
  logic                 epoch_q;
  logic                 epoch_rise;
  logic [AW-1:0]        low_idx;
  logic                 nxt_found;
  logic [AW-1:0]        nxt_idx;
  logic [AW-1:0]        srch_j;
  logic [DWELL_W:0]     cnt_inc;
  logic [DWELL_W:0]     tgt;
  logic [DW-1:0]        cur;

  assign epoch_rise = epoch_in & ~epoch_q;
  assign busy_out   = (state != S_IDLE);
  assign cur        = tbl[idx];
  assign cnt_inc    = {1'b0, cnt} + (DWELL_W+1)'(1);
  assign tgt        = (dwell_q == '0) ? (DWELL_W+1)'(1)
                                      : {1'b0, dwell_q};

  // Previous epoch_in level for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) epoch_q <= 1'b0;
    else           epoch_q <= epoch_in;
  end

  // Scenario table; clear beats a same-cycle write
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      valid <= '0;
      for (int i = 0; i < N_ENTRIES; i++) tbl[i] <= '0;
    end else if (cfg_clr_in) begin
      valid <= '0;
    end else if (cfg_we_in) begin
      tbl[cfg_addr_in]   <= cfg_data_in;
      valid[cfg_addr_in] <= 1'b1;
    end
  end

  // Lowest valid entry, used when starting from IDLE
  always_comb begin
    low_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--)
      if (valid[i]) low_idx = AW'(i);
  end

  // Circular search from idx+1; idx itself is tried last
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = idx;
    srch_j    = idx;
    for (int k = N_ENTRIES; k >= 1; k--) begin
      srch_j = idx + AW'(k);
      if (valid[srch_j]) begin
        nxt_found = 1'b1;
        nxt_idx   = srch_j;
      end
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state              <= S_IDLE;
      idx                <= '0;
      dwell_q            <= '0;
      cnt                <= '0;
      core_ena_out       <= 1'b0;
      n_sat_out          <= '0;
      doppler_out        <= '0;
      snr_out            <= '0;
      ca_phase_out       <= '0;
      ca_phase_start_out <= 1'b0;
      entry_idx_out      <= '0;
      wrap_out           <= 1'b0;
    end else begin
      ca_phase_start_out <= 1'b0;
      wrap_out           <= 1'b0;
      if (!ena_in) begin
        state        <= S_IDLE;
        core_ena_out <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            core_ena_out <= 1'b0;
            if (|valid) begin
              idx   <= low_idx;
              state <= S_LOAD;
            end
          end
          S_LOAD: begin
            ca_phase_out  <= cur[15:0];
            snr_out       <= cur[23:16];
            doppler_out   <= cur[31:24];
            n_sat_out     <= cur[36:32];
            dwell_q       <= cur[DW-1:37];
            entry_idx_out <= idx;
            state         <= S_START;
          end
          S_START: begin
            ca_phase_start_out <= 1'b1;
            core_ena_out       <= 1'b1;
            cnt                <= '0;
            state              <= S_DWELL;
          end
          S_DWELL: begin
            if (epoch_rise) begin
              if (!cnt_inc[DWELL_W]) cnt <= cnt_inc[DWELL_W-1:0];
              if (cnt_inc >= tgt) state <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (nxt_found) begin
              idx      <= nxt_idx;
              wrap_out <= (nxt_idx <= idx);
              state    <= S_LOAD;
            end else begin
              core_ena_out <= 1'b0;
              state        <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gps_scenario_sequencer.sv
// Bench for gps_scenario_sequencer: vector table, directed
// corner sequences and a randomized run against a table-order model.
module tb_gps_scenario_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [44:0] data = '0;
  logic        clr = 1'b0;
  logic        epoch = 1'b0;
  logic        core_ena;
  logic [4:0]  n_sat;
  logic [7:0]  doppler;
  logic [7:0]  snr;
  logic [15:0] ca_phase;
  logic        pls;
  logic [1:0]  eidx;
  logic        busy;
  logic        wrap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gps_scenario_sequencer #(.N_ENTRIES(4), .DWELL_W(8)) dut (
    .clk_in(clk), .rst_in_n(rst_n), .ena_in(ena),
    .cfg_we_in(we), .cfg_addr_in(addr), .cfg_data_in(data),
    .cfg_clr_in(clr), .epoch_in(epoch),
    .core_ena_out(core_ena), .n_sat_out(n_sat),
    .doppler_out(doppler), .snr_out(snr),
    .ca_phase_out(ca_phase), .ca_phase_start_out(pls),
    .entry_idx_out(eidx), .busy_out(busy), .wrap_out(wrap)
  );

  typedef struct {
    logic       ena;
    logic       ep;
    logic       busy;
    logic       core;
    logic       pls;
    logic       wrap;
    logic [4:0] nsat;
    logic [7:0] dop;
    logic [1:0] idx;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [44:0] mk(input logic [7:0] dw,
    input logic [4:0] ns, input logic [7:0] dp,
    input logic [7:0] sn, input logic [15:0] ph);
    return {dw, ns, dp, sn, ph};
  endfunction

  task automatic wr(input logic [1:0] a, input logic [44:0] d);
    we = 1'b1; addr = a; data = d;
    step();
    we = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic ep_step(input logic e);
    epoch = e;
    step();
  endtask

  // randomized run state
  logic [44:0] rt [4];
  int          rdw [4];
  int          order [$];
  int          pos, prev, npls, since, gap, cyc, k, mdw;
  logic        started, wseen;
  logic [3:0]  vmask;

  initial begin
    tv[0]  = '{1,0, 1,0,0,0, 5'd0,  8'h00, 2'd0};
    tv[1]  = '{1,0, 1,0,0,0, 5'd5,  8'h10, 2'd0};
    tv[2]  = '{1,0, 1,1,1,0, 5'd5,  8'h10, 2'd0};
    tv[3]  = '{1,1, 1,1,0,0, 5'd5,  8'h10, 2'd0};
    tv[4]  = '{1,0, 1,1,0,0, 5'd5,  8'h10, 2'd0};
    tv[5]  = '{1,1, 1,1,0,0, 5'd5,  8'h10, 2'd0};
    tv[6]  = '{1,0, 1,1,0,0, 5'd5,  8'h10, 2'd0};
    tv[7]  = '{1,1, 1,1,0,0, 5'd5,  8'h10, 2'd0};
    tv[8]  = '{1,0, 1,1,0,0, 5'd5,  8'h10, 2'd0};
    tv[9]  = '{1,0, 1,1,0,0, 5'd12, 8'h33, 2'd2};
    tv[10] = '{1,0, 1,1,1,0, 5'd12, 8'h33, 2'd2};
    tv[11] = '{1,1, 1,1,0,0, 5'd12, 8'h33, 2'd2};
    tv[12] = '{1,0, 1,1,0,0, 5'd12, 8'h33, 2'd2};
    tv[13] = '{1,1, 1,1,0,0, 5'd12, 8'h33, 2'd2};
    tv[14] = '{1,0, 1,1,0,1, 5'd12, 8'h33, 2'd2};
    tv[15] = '{1,0, 1,1,0,0, 5'd5,  8'h10, 2'd0};
    tv[16] = '{1,0, 1,1,1,0, 5'd5,  8'h10, 2'd0};

    step();
    // reset held while inputs toggle
    ena = 1'b1; we = 1'b1; data = mk(3, 5, 8'h10, 8'h22, 16'h1234);
    for (int i = 0; i < 6; i++) begin
      epoch = ~epoch;
      step();
    end
    chk("rst_busy", busy, 0);
    chk("rst_core", core_ena, 0);
    chk("rst_pls", pls, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_cfg", {n_sat, doppler, snr, ca_phase}, 0);
    chk("rst_idx", eidx, 0);
    rst_n = 1'b1; we = 1'b0; epoch = 1'b0;
    repeat (4) step();
    chk("rst_no_valid", busy, 0);
    ena = 1'b0;
    step();

    // two-entry sequence from the vector table
    wr(0, mk(3, 5, 8'h10, 8'h00, 16'h0100));
    wr(2, mk(2, 12, 8'h33, 8'h00, 16'h0200));
    for (int i = 0; i < 17; i++) begin
      ena = tv[i].ena; epoch = tv[i].ep;
      step();
      chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("v%0d_core", i), core_ena, tv[i].core);
      chk($sformatf("v%0d_pls", i), pls, tv[i].pls);
      chk($sformatf("v%0d_wrap", i), wrap, tv[i].wrap);
      chk($sformatf("v%0d_nsat", i), n_sat, tv[i].nsat);
      chk($sformatf("v%0d_dop", i), doppler, tv[i].dop);
      chk($sformatf("v%0d_idx", i), eidx, tv[i].idx);
    end
    ena = 1'b0;
    step();

    // single entry with dwell 0 reloads every epoch
    clear();
    wr(1, mk(0, 7, 8'h44, 8'h55, 16'h0777));
    ena = 1'b1;
    repeat (3) step();
    chk("d0_first_pls", pls, 1);
    chk("d0_first_idx", eidx, 1);
    chk("d0_nsat", n_sat, 7);
    for (int i = 0; i < 3; i++) begin
      ep_step(1);
      ep_step(0);
      chk($sformatf("d0_wrap%0d", i), wrap, 1);
      step();
      chk($sformatf("d0_nopls%0d", i), pls, 0);
      step();
      chk($sformatf("d0_pls%0d", i), pls, 1);
      chk($sformatf("d0_idx%0d", i), eidx, 1);
    end
    ena = 1'b0;
    step();

    // rewrite of the active entry waits for the next load
    clear();
    wr(0, mk(2, 3, 8'h10, 8'h01, 16'h0001));
    ena = 1'b1;
    repeat (3) step();
    chk("rw_pls", pls, 1);
    wr(0, mk(2, 3, 8'h20, 8'h01, 16'h0001));
    chk("rw_hold0", doppler, 8'h10);
    ep_step(1);
    ep_step(0);
    chk("rw_hold1", doppler, 8'h10);
    ep_step(1);
    ep_step(0);
    chk("rw_hold2", doppler, 8'h10);
    step();
    chk("rw_new", doppler, 8'h20);
    step();
    chk("rw_pls2", pls, 1);
    ena = 1'b0;
    step();

    // clear during dwell of entry 1
    clear();
    wr(0, mk(1, 1, 8'h01, 8'h00, 16'h0000));
    wr(1, mk(2, 2, 8'h02, 8'h00, 16'h0000));
    ena = 1'b1;
    repeat (3) step();
    ep_step(1);
    ep_step(0);
    step();
    step();
    chk("clr_pls", pls, 1);
    chk("clr_idx", eidx, 1);
    clear();
    chk("clr_busy_mid", busy, 1);
    chk("clr_core_mid", core_ena, 1);
    ep_step(1);
    ep_step(0);
    ep_step(1);
    chk("clr_busy_next", busy, 1);
    ep_step(0);
    chk("clr_busy_end", busy, 0);
    chk("clr_core_end", core_ena, 0);
    chk("clr_nsat_hold", n_sat, 2);
    ena = 1'b0;
    step();

    // enable dropped in START and in DWELL
    wr(0, mk(1, 1, 8'h01, 8'h00, 16'h0000));
    wr(1, mk(1, 2, 8'h02, 8'h00, 16'h0000));
    ena = 1'b1;
    repeat (2) step();
    ena = 1'b0;
    step();
    chk("en_st_busy", busy, 0);
    chk("en_st_core", core_ena, 0);
    chk("en_st_pls", pls, 0);
    step();
    chk("en_st_pls2", pls, 0);
    ena = 1'b1;
    repeat (3) step();
    chk("en_re_pls", pls, 1);
    chk("en_re_idx", eidx, 0);
    ep_step(1);
    ep_step(0);
    step();
    step();
    chk("en_e1_idx", eidx, 1);
    ena = 1'b0;
    step();
    chk("en_dw_busy", busy, 0);
    chk("en_dw_core", core_ena, 0);
    chk("en_dw_hold", n_sat, 2);
    ena = 1'b1;
    repeat (3) step();
    chk("en_dw_pls", pls, 1);
    chk("en_dw_idx", eidx, 0);
    chk("en_dw_nsat", n_sat, 1);
    ena = 1'b0;
    step();

    // randomized tables, order and dwell counts from a queue model
    for (int it = 0; it < 4; it++) begin
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      vmask = 4'($urandom_range(1, 15));
      order.delete();
      for (int i = 0; i < 4; i++) begin
        rdw[i] = $urandom_range(0, 4);
        rt[i] = mk(8'(rdw[i]), 5'($urandom), 8'($urandom),
                   8'($urandom), 16'($urandom));
        if (vmask[i]) begin
          wr(2'(i), rt[i]);
          order.push_back(i);
        end
      end
      ena = 1'b1;
      pos = 0; prev = -1; npls = 0; since = 0;
      gap = 0; cyc = 0; started = 1'b0; wseen = 1'b0;
      while (npls < 10 && cyc < 2000) begin
        if (wrap) wseen = 1'b1;
        if (pls) begin
          k = order[pos];
          chk("rnd_idx", eidx, k);
          chk("rnd_cfg", {n_sat, doppler, snr, ca_phase},
              rt[k][36:0]);
          chk("rnd_core", core_ena, 1);
          if (prev >= 0) begin
            mdw = (rdw[prev] == 0) ? 1 : rdw[prev];
            chk("rnd_epochs", since, mdw);
            chk("rnd_wrap", wseen, k <= prev);
          end else begin
            chk("rnd_wrap0", wseen, 0);
          end
          prev = k;
          pos = (pos + 1) % order.size();
          since = 0;
          wseen = 1'b0;
          npls++;
          started = 1'b1;
        end
        if (started && gap == 0) begin
          epoch = 1'b1;
          since++;
          gap = $urandom_range(8, 12);
        end else begin
          epoch = 1'b0;
          if (gap > 0) gap--;
        end
        step();
        cyc++;
      end
      chk("rnd_timeout", npls, 10);
      ena = 1'b0;
      epoch = 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
